// File: rtl/xbox_mem_responder.sv
// XBOX accelerator memory responder: NUM_MEMS banks of 256-bit lines with
// one-cycle XLR read/write ports and a lower-priority host word port.
module xbox_mem_responder #(
  parameter int unsigned NUM_MEMS           = 1,
  parameter int unsigned LOG2_LINES_PER_MEM = 4,
  parameter int unsigned SEL_W              = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  xlr_mem_addr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_wdata,
  input  logic [NUM_MEMS-1:0][31:0]                    xlr_mem_be,
  input  logic [NUM_MEMS-1:0]                          xlr_mem_rd,
  input  logic [NUM_MEMS-1:0]                          xlr_mem_wr,
  output logic [NUM_MEMS-1:0][7:0][31:0]               xlr_mem_rdata,
  input  logic                                         host_req,
  input  logic                                         host_we,
  input  logic [SEL_W-1:0]                             host_sel,
  input  logic [LOG2_LINES_PER_MEM-1:0]                host_addr,
  input  logic [2:0]                                   host_word,
  input  logic [3:0]                                   host_be,
  input  logic [31:0]                                  host_wdata,
  output logic                                         host_gnt,
  output logic                                         host_rvalid,
  output logic [31:0]                                  host_rdata,
  output logic [15:0]                                  conflict_cnt
);

  localparam int unsigned LINES = 1 << LOG2_LINES_PER_MEM;

  logic [NUM_MEMS-1:0][LINES-1:0][7:0][31:0] mem;

  logic        sel_ok_c;
  logic        busy_c;
  logic [31:0] host_word_c;
  logic        host_wr_c;
  logic        host_rd_c;

  // Decode the host bank select; an unmatched select means an out-of-range bank.
  always_comb begin
    sel_ok_c    = 1'b0;
    busy_c      = 1'b0;
    host_word_c = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (host_sel == SEL_W'(m)) begin
        sel_ok_c    = 1'b1;
        busy_c      = xlr_mem_rd[m] | xlr_mem_wr[m];
        host_word_c = mem[m][host_addr][host_word];
      end
    end
  end

  // Accelerator always wins its own bank; the host is never denied elsewhere.
  assign host_gnt  = host_req & ~busy_c;
  assign host_wr_c = host_gnt & host_we & sel_ok_c;
  assign host_rd_c = host_gnt & ~host_we;

  // Storage: host writes only land on banks the accelerator is not touching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int m = 0; m < NUM_MEMS; m++) begin
        if (xlr_mem_wr[m]) begin
          for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 4; b++) begin
              if (xlr_mem_be[m][w*4+b]) begin
                mem[m][xlr_mem_addr[m]][w][b*8 +: 8] <= xlr_mem_wdata[m][w][b*8 +: 8];
              end
            end
          end
        end else if (host_wr_c && (host_sel == SEL_W'(m))) begin
          for (int b = 0; b < 4; b++) begin
            if (host_be[b]) begin
              mem[m][host_addr][host_word][b*8 +: 8] <= host_wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // XLR read data samples the pre-write line and holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xlr_mem_rdata <= '0;
    end else begin
      for (int m = 0; m < NUM_MEMS; m++) begin
        if (xlr_mem_rd[m]) begin
          xlr_mem_rdata[m] <= mem[m][xlr_mem_addr[m]];
        end
      end
    end
  end

  // Host read return and saturating denial counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      host_rvalid <= host_rd_c;
      if (host_rd_c) begin
        host_rdata <= sel_ok_c ? host_word_c : 32'h0;
      end
      if (host_req && !host_gnt && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xbox_mem_responder.sv
// Randomized self-checking bench for xbox_mem_responder against a word-array
// reference model; three banks so host_sel=3 exercises the out-of-range path.
module tb_xbox_mem_responder;

  localparam int NM = 3;
  localparam int SW = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NM-1:0][3:0]       xa;
  logic [NM-1:0][7:0][31:0] xwd;
  logic [NM-1:0][31:0]      xbe;
  logic [NM-1:0]            xrd;
  logic [NM-1:0]            xwr;
  logic [NM-1:0][7:0][31:0] xrdata;
  logic                     host_req;
  logic                     host_we;
  logic [SW-1:0]            host_sel;
  logic [3:0]               host_addr;
  logic [2:0]               host_word;
  logic [3:0]               host_be;
  logic [31:0]              host_wdata;
  logic                     host_gnt;
  logic                     host_rvalid;
  logic [31:0]              host_rdata;
  logic [15:0]              conflict_cnt;

  // Reference state
  logic [31:0]         mm [NM][16][8];
  logic [NM-1:0][255:0] exp_xr;
  logic [31:0]         exp_hr;
  logic                exp_rv;
  logic [15:0]         exp_cc;
  logic                exp_gnt;
  int                  n_vec = 0;
  int                  n_bad = 0;

  xbox_mem_responder #(.NUM_MEMS(NM), .LOG2_LINES_PER_MEM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .xlr_mem_addr(xa), .xlr_mem_wdata(xwd), .xlr_mem_be(xbe),
    .xlr_mem_rd(xrd), .xlr_mem_wr(xwr), .xlr_mem_rdata(xrdata),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_word(host_word), .host_be(host_be),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input int m, input int a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mm[m][a][w];
    return l;
  endfunction

  task automatic idle();
    xa = '0; xwd = '0; xbe = '0; xrd = '0; xwr = '0;
    host_req = 1'b0; host_we = 1'b0; host_sel = '0; host_addr = '0;
    host_word = '0; host_be = '0; host_wdata = '0;
  endtask

  task automatic clear_model();
    for (int m = 0; m < NM; m++)
      for (int a = 0; a < 16; a++)
        for (int w = 0; w < 8; w++) mm[m][a][w] = 32'h0;
    exp_xr = '0; exp_hr = '0; exp_rv = 1'b0; exp_cc = '0; exp_gnt = 1'b0;
  endtask

  // Apply current inputs for one clock and compare every output afterwards.
  task automatic tick();
    logic [NM-1:0][255:0] pre;
    logic ok, busy;
    int   s;
    #1;
    s    = int'(host_sel);
    ok   = (s < NM);
    busy = ok && (xrd[s] || xwr[s]);
    exp_gnt = host_req && !busy;
    check("gnt", 256'(host_gnt), 256'(exp_gnt));
    for (int m = 0; m < NM; m++) pre[m] = line_of(m, int'(xa[m]));
    for (int m = 0; m < NM; m++) if (xrd[m]) exp_xr[m] = pre[m];
    if (exp_gnt && !host_we) begin
      exp_hr = ok ? mm[s][host_addr][host_word] : 32'h0;
      exp_rv = 1'b1;
    end else begin
      exp_rv = 1'b0;
    end
    if (host_req && !exp_gnt && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
    for (int m = 0; m < NM; m++)
      if (xwr[m])
        for (int i = 0; i < 32; i++)
          if (xbe[m][i]) mm[m][xa[m]][i/4][(i%4)*8 +: 8] = xwd[m][i/4][(i%4)*8 +: 8];
    if (exp_gnt && host_we && ok)
      for (int b = 0; b < 4; b++)
        if (host_be[b]) mm[s][host_addr][host_word][b*8 +: 8] = host_wdata[b*8 +: 8];
    @(posedge clk); #1;
    for (int m = 0; m < NM; m++) check("xlr_rdata", 256'(xrdata[m]), exp_xr[m]);
    check("rvalid", 256'(host_rvalid), 256'(exp_rv));
    check("host_rdata", 256'(host_rdata), 256'(exp_hr));
    check("conflict_cnt", 256'(conflict_cnt), 256'(exp_cc));
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst_n = 1'b0;
    clear_model();
    repeat (cycles) begin
      @(posedge clk); #1;
      check("rst_rvalid", 256'(host_rvalid), 256'(0));
      check("rst_cnt", 256'(conflict_cnt), 256'(0));
    end
    rst_n = 1'b1;
  endtask

  task automatic host_op(input logic we, input int sel, input int a, input int w,
                         input logic [3:0] be, input logic [31:0] d);
    host_req = 1'b1; host_we = we; host_sel = SW'(sel); host_addr = 4'(a);
    host_word = 3'(w); host_be = be; host_wdata = d;
  endtask

  initial begin
    logic [255:0] ref_line;
    idle();
    rst_n = 1'b0;
    clear_model();
    do_reset(3);

    // Cleared memory reads back as zero at both ends of the bank
    xrd[0] = 1'b1; xa[0] = 4'd0;  tick();
    check("reset_line0", 256'(xrdata[0]), 256'(0));
    xa[0] = 4'd15; tick();
    check("reset_line15", 256'(xrdata[0]), 256'(0));
    idle();

    // Host preload of bank 0 line 0, then accelerator read of the whole line
    for (int w = 0; w < 8; w++) begin
      host_op(1'b1, 0, 0, w, 4'hF, 32'(w + 1));
      tick();
    end
    idle();
    xrd[0] = 1'b1; xa[0] = 4'd0; tick();
    for (int w = 0; w < 8; w++) ref_line[w*32 +: 32] = 32'(w + 1);
    check("preload_line", 256'(xrdata[0]), ref_line);
    idle();

    // Partial XLR write: only the low word's bytes are enabled
    xwr[0] = 1'b1; xa[0] = 4'd1; xbe[0] = 32'hFFFF_FFFF; tick();
    xbe[0] = 32'h0000_000F; xwd[0][0] = 32'hDEADBEEF; xwd[0][1] = 32'h1; tick();
    idle();
    host_op(1'b0, 0, 1, 0, 4'hF, 32'h0); tick();
    idle(); tick();
    check("partial_w0", 256'(host_rdata), 256'(32'hDEADBEEF));
    host_op(1'b0, 0, 1, 1, 4'hF, 32'h0); tick();
    idle(); tick();
    check("partial_w1", 256'(host_rdata), 256'(0));

    // Simultaneous read and write of the same line returns the old line
    xwr[0] = 1'b1; xa[0] = 4'd1; xbe[0] = 32'hFFFF_FFFF; xwd[0][0] = 32'h11; tick();
    xrd[0] = 1'b1; xwd[0][0] = 32'h22; tick();
    check("rw_old", 256'(xrdata[0][0]), 256'(32'h11));
    xwr[0] = 1'b0; tick();
    check("rw_new", 256'(xrdata[0][0]), 256'(32'h22));
    idle();

    // Host held off by the accelerator for three cycles
    host_op(1'b0, 0, 0, 2, 4'hF, 32'h0);
    xrd[0] = 1'b1; xa[0] = 4'd5;
    repeat (3) tick();
    check("conflict_3", 256'(conflict_cnt), 256'(3));
    xrd[0] = 1'b0; tick();
    idle(); tick();
    check("conflict_data", 256'(host_rdata), 256'(3));

    // Out-of-range bank: granted, writes dropped, reads return zero
    host_op(1'b1, 3, 0, 0, 4'hF, 32'hCAFE_F00D); tick();
    host_op(1'b0, 3, 0, 0, 4'hF, 32'h0); tick();
    idle(); tick();

    // Randomized traffic; host holds a denied request unchanged
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < NM; m++) begin
        xrd[m] = ($urandom_range(0, 2) == 0);
        xwr[m] = ($urandom_range(0, 2) == 0);
        xa[m]  = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2));
        xbe[m] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        for (int w = 0; w < 8; w++) xwd[m][w] = $urandom;
      end
      if (!(host_req && !exp_gnt)) begin
        if ($urandom_range(0, 1) == 1)
          host_op(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 7)), 4'($urandom), $urandom);
        else
          host_req = 1'b0;
      end
      tick();
    end
    idle(); tick();

    // Reset arriving while a granted host read is in flight
    host_op(1'b1, 0, 0, 0, 4'hF, 32'hA5A5_5A5A); tick();
    host_op(1'b0, 0, 0, 0, 4'hF, 32'h0);
    #1;
    check("midrst_gnt", 256'(host_gnt), 256'(1));
    #2;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk); #1;
    check("midrst_rvalid", 256'(host_rvalid), 256'(0));
    check("midrst_rdata", 256'(host_rdata), 256'(0));
    do_reset(2);
    tick();
    xrd[0] = 1'b1; xa[0] = 4'd0; tick();
    check("midrst_mem", 256'(xrdata[0]), 256'(0));
    idle();
    host_op(1'b0, 0, 0, 0, 4'hF, 32'h0); tick();
    idle(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xbox_mem_responder.md
# xbox_mem_responder

Responder side of the XBOX accelerator memory interface: NUM_MEMS banks of 2^LOG2_LINES_PER_MEM lines × 256 bits, each serving the accelerator's addr/rd/wr/be/wdata requests with one-cycle registered read data. A second, lower-priority host word port lets SoC software and the testbench preload operands and read back results. It sits between the accelerator and the SoC fabric and replaces the behavioural memory model in simulation.

## Interface
- NUM_MEMS, 1: number of independent memory banks
- LOG2_LINES_PER_MEM, 4: address bits per bank (16 lines of 256 bits)
- SEL_W, (NUM_MEMS>1 ? $clog2(NUM_MEMS) : 1): width of the host bank select

- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- xlr_mem_addr  in  [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]  line address per bank
- xlr_mem_wdata  in  [NUM_MEMS-1:0][7:0][31:0]  write line (8 × 32-bit words)
- xlr_mem_be  in  [NUM_MEMS-1:0][31:0]  byte enable; bit i covers line byte i (word i/4)
- xlr_mem_rd  in  [NUM_MEMS-1:0]  read request
- xlr_mem_wr  in  [NUM_MEMS-1:0]  write request
- xlr_mem_rdata  out  [NUM_MEMS-1:0][7:0][31:0]  registered read line
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_sel  in  SEL_W  target bank
- host_addr  in  LOG2_LINES_PER_MEM  line address
- host_word  in  3  word index within the line
- host_be  in  4  byte enables for the 32-bit word
- host_wdata  in  32  host write word
- host_gnt  out  1  combinational grant, same cycle as host_req
- host_rvalid  out  1  one-cycle pulse: host_rdata valid
- host_rdata  out  32  host read word
- conflict_cnt  out  16  saturating count of host requests denied

## Operation
- Storage: per bank, array mem[2^L][8][32]. All lines are cleared to 0 on reset.
- XLR read: when xlr_mem_rd[m] is 1 at a posedge, xlr_mem_rdata[m] <= mem[m][addr]. When rd is 0, rdata holds its last value.
- XLR write: when xlr_mem_wr[m] is 1 at a posedge, each byte i with be[i]=1 takes wdata byte i. Bytes with be[i]=0 are unchanged. be=0 with wr=1 is a legal no-op.
- rd and wr in the same cycle on the same bank, same address: the write happens, and rdata returns the pre-write (old) line.
- Host arbitration: host_gnt = host_req & ~(xlr_mem_rd[host_sel] | xlr_mem_wr[host_sel]). The accelerator always wins.
  - A host request to a bank with no XLR activity is granted in the same cycle, including while the accelerator is using other banks.
  - The host holds the request until it sees gnt.
- Host write (granted): byte-enabled update of word host_word in the addressed line.
- Host read (granted): host_rdata <= that word, and host_rvalid pulses the next cycle.
- host_sel >= NUM_MEMS: host_gnt = 1, writes are dropped, reads return 32'h0 with rvalid.
- conflict_cnt increments each cycle with host_req=1 and host_gnt=0. It saturates at 16'hFFFF.
- The block has no internal FSM beyond arbitration. It is a request-per-cycle pipeline: a new request is accepted every cycle on every port.

## Timing
- Reset values: xlr_mem_rdata=0, host_rdata=0, host_rvalid=0, conflict_cnt=0, memory contents=0. host_gnt is combinational.
- Read latency is 1 cycle on both ports: request at edge N, data valid after edge N, sampled by the requester at edge N+1.
- Write-to-read: a write at edge N is visible to a read request presented at edge N+1.
- Back-to-back XLR reads on consecutive cycles return consecutive lines with no bubble.
- Reset asserted mid-transaction clears pending rdata/rvalid and contents immediately. Requests present during reset are ignored.

## Test plan
- Reset: deassert rst_n after 3 cycles, then XLR-read line 0 and line 15 -> rdata = 0. conflict_cnt = 0, host_rvalid = 0.
- Host preload: write words 0..7 of bank 0 line 0 = 1,2,3,4,5,6,7,8 with be=4'hF. XLR read addr 0 -> next cycle rdata[0] = {8,7,6,5,4,3,2,1} (word 7..0).
- XLR partial write: line 1 = 0, then wr with be=32'h0000_000F and wdata word0=32'hDEADBEEF, word1=32'h1. Host reads line 1 word 0 -> 32'hDEADBEEF, word 1 -> 0.
- Simultaneous rd+wr on addr 1 holding 32'h11 in word 0, writing 32'h22 with full be -> rdata word0 = 32'h11 that cycle. A read next cycle returns 32'h22.
- Conflict: host_req read on bank 0 while xlr_mem_rd[0] is held for 3 cycles -> gnt = 0 for 3 cycles, conflict_cnt = 3, then gnt = 1 and rvalid one cycle later with the correct word.
- Reset mid-operation: assert rst_n low in the cycle after a host read grant -> host_rvalid never pulses and the memory reads back 0 after reset.
